// File: rtl/lockin_result_poller.sv
// Avalon-MM read initiator that snapshots N_CH lock-in result ports, on a start
// pulse or periodically, and publishes them all at once with a one-cycle strobe.
module lockin_result_poller #(
    parameter int DATA_W       = 32,
    parameter int N_CH         = 2,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 1,
    parameter int PERIOD_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     auto_en,
    input  logic [PERIOD_W-1:0]      period,
    output logic [ADDR_W-1:0]        avm_address,
    output logic                     avm_read,
    input  logic                     avm_waitrequest,
    input  logic [DATA_W-1:0]        avm_readdata,
    output logic [N_CH*DATA_W-1:0]   result_data,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int LAT_W = 3;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [PERIOD_W-1:0]      cnt_q, cnt_d;
    logic [N_CH*DATA_W-1:0]   shadow_q, shadow_d;
    logic [N_CH*DATA_W-1:0]   result_q, result_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    logic [PERIOD_W-1:0]      periodLast;
    logic                     expire;
    logic                     trigger;
    logic                     ready;

    // A period of 0 behaves like 1; ">=" lets a shortened period take effect at once.
    assign periodLast = (period == '0) ? '0 : period - 1'b1;
    assign expire     = auto_en && (cnt_q >= periodLast);
    assign trigger    = start || expire;

    // The strobe cycle still belongs to the snapshot, so triggers there are dropped.
    assign ready = (state_q == IDLE) && !valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            lat_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            lat_q     <= lat_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        lat_d     = lat_q;
        shadow_d  = shadow_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        cnt_d     = '0;

        if (auto_en && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (trigger && !ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger && ready) begin
                    state_d = ISSUE;
                    ch_d    = '0;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    state_d = WAIT;
                    lat_d   = '0;
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    shadow_d[int'(ch_q)*DATA_W +: DATA_W] = avm_readdata;
                    if (ch_q == CH_LAST) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            DONE: begin
                result_d = shadow_q;
                valid_d  = 1'b1;
                ch_d     = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign avm_read     = (state_q == ISSUE);
    assign avm_address  = ADDR_W'({ch_q, 2'b00});
    assign result_data  = result_q;
    assign result_valid = valid_q;
    assign busy         = (state_q != IDLE) || valid_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/lockin_result_poller.md
Name: lockin_result_poller

Overview:
- Avalon-MM read initiator that fetches lock-in result words (in-phase, quadrature) from read-only 32-bit input-port responders.
- Each responder decodes a 2-bit word address, returns data only at offset 0, and registers readdata with a fixed 1-cycle read latency.
- The block reads all channels as one snapshot, either on a start pulse or periodically, and presents the snapshot as a flat result bus with a one-cycle valid strobe.
- It sits between the processor-side result ports and downstream logging/DMA logic.

Parameters:
- DATA_W, 32: read data width.
- N_CH, 2: number of responders polled per snapshot (1..8).
- ADDR_W, 5: initiator word-address width; must be >= 2 + clog2(N_CH).
- READ_LATENCY, 1: cycles from accepted read to valid readdata (1..4).
- PERIOD_W, 16: width of the auto-poll period counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request for one snapshot.
- auto_en  in  1  1 = repeat a snapshot every `period` cycles.
- period  in  PERIOD_W  auto-poll interval in cycles; 0 is treated as 1.
- avm_address  out  ADDR_W  word address = ch*4 + 0.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  responder stall; tie to 0 for port responders.
- avm_readdata  in  DATA_W  responder data.
- result_data  out  N_CH*DATA_W  snapshot; channel k occupies bits [k*DATA_W +: DATA_W].
- result_valid  out  1  one-cycle strobe when result_data is updated.
- busy  out  1  high from snapshot launch until result_valid.
- overrun  out  1  sticky; set when a trigger is dropped while busy.

Behaviour:
- Reset (synchronous, active-high, highest priority): state IDLE; avm_read=0; avm_address=0; result_data=0; result_valid=0; busy=0; overrun=0; period counter=0; channel index=0. Reset mid-transaction abandons the read; a late readdata is ignored.
- Trigger = start | (auto_en & period counter expired).
  - Period counter counts clk cycles while auto_en=1 and expires when count reaches max(period,1)-1.
  - It reloads to 0 on expiry and holds at 0 while auto_en=0.
- States:
  - IDLE: busy=0. On trigger → ISSUE with ch=0 and busy=1 on the next cycle.
  - ISSUE: avm_read=1, avm_address=ch*4. Address and read stay stable while avm_waitrequest=1. On the cycle with avm_waitrequest=0 the read is accepted → WAIT.
  - WAIT: avm_read=0. A latency counter counts READ_LATENCY cycles after acceptance; avm_readdata is sampled on the cycle the count completes, i.e. exactly READ_LATENCY clocks after the accepting edge. The word goes into a shadow register for channel ch. Then: if ch<N_CH-1, ch++ → ISSUE; else → DONE.
  - DONE: copy all shadow registers into result_data at once, so partial snapshots are never visible. result_valid=1 for this one cycle, busy drops with it. → IDLE.
- One outstanding read at a time; no pipelining.
- Snapshot length with waitrequest=0: N_CH*(1+READ_LATENCY) cycles + 1 DONE cycle. With N_CH=2 and latency 1, start at cycle 0 gives result_valid at cycle 6.
- Trigger while state≠IDLE: dropped and overrun set to 1; it stays set until reset.
- A trigger in the DONE cycle also counts as dropped.
- start and an auto expiry in the same cycle count as one trigger.
- result_data holds its value between snapshots.
- Changing period mid-count takes effect at the next comparison.

Test Plan:
1. Basic snapshot. Reset, then start pulse; responders return 0x12345678 (ch0) and 0x9ABCDEF0 (ch1) with latency 1 and waitrequest=0.
   → addresses 0 then 4; result_valid at cycle 6; result_data = {0x9ABCDEF0, 0x12345678}; busy high for cycles 1–6.
2. Waitrequest. Assert waitrequest for 3 cycles on the ch1 read.
   → avm_read and avm_address=4 held stable for those 3 cycles; result_valid delayed by 3 cycles; data still correct.
3. Auto mode. auto_en=1, period=20, start never pulsed.
   → result_valid every 20 cycles; overrun stays 0.
4. period=0 with auto_en=1.
   → treated as 1; the period counter expires every cycle, overrun=1 after the first snapshot, and snapshots run back-to-back.
5. Overrun. Start at cycle 0 and start again at cycle 3.
   → only one snapshot; overrun=1 from cycle 4 onward; a later reset clears it to 0.
6. Reset mid-read. Assert reset in WAIT on ch0.
   → next cycle all outputs are 0 and state is IDLE; the stale readdata does not update result_data; a fresh start completes normally.
